// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types and constants
package uart_pkg;

  localparam int OVS_DEFAULT = 16;
  localparam int DATA_W      = 8;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_WAIT
  } rx_state_t;

endpackage

// File: rtl/uart2_dut.sv
// rtl/uart2_dut.sv - second UART channel, same core with _2 port names
module uart2_dut
  import uart_pkg::*;
#(
  parameter int OVS = OVS_DEFAULT
) (
  input  logic              clk_sis,
  input  logic              rst,
  input  logic              clk_uart,
  input  logic              start_bit_2,
  input  logic [DATA_W-1:0] data_in_2,
  input  logic              stop_bit_2,
  output logic              tx2,
  input  logic              rx2,
  output logic [DATA_W-1:0] data_out_2,
  output logic              rx_valid_2,
  output logic              frame_err_2,
  output logic              tx_busy_2
);

  uart1_dut #(.OVS(OVS)) u_core (
    .clk_sis     (clk_sis),
    .rst         (rst),
    .clk_uart    (clk_uart),
    .start_bit   (start_bit_2),
    .data_in_1   (data_in_2),
    .stop_bit    (stop_bit_2),
    .tx1         (tx2),
    .rx1         (rx2),
    .data_out_1  (data_out_2),
    .rx_valid_1  (rx_valid_2),
    .frame_err_1 (frame_err_2),
    .tx_busy_1   (tx_busy_2)
  );

endmodule

// File: rtl/uart_tick_gen.sv
// rtl/uart_tick_gen.sv - oversample strobe synchronizer and rising-edge tick
module uart_tick_gen (
  input  logic clk_sis,
  input  logic rst,
  input  logic strobe,
  output logic tick
);

  logic [1:0] sync;
  logic       prev;

  // Two-flop synchronizer, then a registered rising-edge detect (strobe rise to tick = 3 cycles)
  always_ff @(posedge clk_sis or negedge rst) begin
    if (!rst) begin
      sync <= 2'b00;
      prev <= 1'b0;
      tick <= 1'b0;
    end else begin
      sync <= {sync[0], strobe};
      prev <= sync[1];
      tick <= sync[1] & ~prev;
    end
  end

endmodule

// File: rtl/uart1_dut.sv
// rtl/uart1_dut.sv - full-duplex 8N1/8N2 UART core
module uart1_dut
  import uart_pkg::*;
#(
  parameter int OVS = OVS_DEFAULT
) (
  input  logic              clk_sis,
  input  logic              rst,
  input  logic              clk_uart,
  input  logic              start_bit,
  input  logic [DATA_W-1:0] data_in_1,
  input  logic              stop_bit,
  output logic              tx1,
  input  logic              rx1,
  output logic [DATA_W-1:0] data_out_1,
  output logic              rx_valid_1,
  output logic              frame_err_1,
  output logic              tx_busy_1
);

  localparam int            CW   = (OVS > 2) ? $clog2(OVS) : 1;
  localparam logic [CW-1:0] LAST = CW'(OVS - 1);
  localparam logic [CW-1:0] HALF = CW'(OVS / 2 - 1);

  logic tick;

  uart_tick_gen u_tick (
    .clk_sis (clk_sis),
    .rst     (rst),
    .strobe  (clk_uart),
    .tick    (tick)
  );

  // ---------------- transmitter ----------------
  tx_state_t         tx_state;
  logic [CW-1:0]     tx_cnt;
  logic [2:0]        tx_bit;
  logic [DATA_W-1:0] tx_shreg;
  logic              tx_two_stop;
  logic              tx_stop_idx;

  // TX FSM: a request is latched while idle; the frame itself starts on the following tick
  always_ff @(posedge clk_sis or negedge rst) begin
    if (!rst) begin
      tx_state    <= TX_IDLE;
      tx1         <= 1'b1;
      tx_busy_1   <= 1'b0;
      tx_cnt      <= '0;
      tx_bit      <= 3'd0;
      tx_shreg    <= '0;
      tx_two_stop <= 1'b0;
      tx_stop_idx <= 1'b0;
    end else begin
      case (tx_state)
        TX_IDLE: begin
          if (!tx_busy_1) begin
            if (start_bit) begin
              tx_shreg    <= data_in_1;
              tx_two_stop <= stop_bit;
              tx_busy_1   <= 1'b1;
            end
          end else if (tick) begin
            tx_state <= TX_START;
            tx1      <= 1'b0;
            tx_cnt   <= '0;
          end
        end
        TX_START: begin
          if (tick) begin
            if (tx_cnt == LAST) begin
              tx_cnt   <= '0;
              tx_bit   <= 3'd0;
              tx1      <= tx_shreg[0];
              tx_state <= TX_DATA;
            end else begin
              tx_cnt <= tx_cnt + CW'(1);
            end
          end
        end
        TX_DATA: begin
          if (tick) begin
            if (tx_cnt == LAST) begin
              tx_cnt <= '0;
              if (tx_bit == 3'd7) begin
                tx1         <= 1'b1;
                tx_stop_idx <= 1'b0;
                tx_state    <= TX_STOP;
              end else begin
                tx_bit   <= tx_bit + 3'd1;
                tx_shreg <= {1'b0, tx_shreg[DATA_W-1:1]};
                tx1      <= tx_shreg[1];
              end
            end else begin
              tx_cnt <= tx_cnt + CW'(1);
            end
          end
        end
        TX_STOP: begin
          if (tick) begin
            if (tx_cnt == LAST) begin
              tx_cnt <= '0;
              if (tx_two_stop && !tx_stop_idx) begin
                tx_stop_idx <= 1'b1;
              end else begin
                tx_busy_1 <= 1'b0;
                tx_state  <= TX_IDLE;
              end
            end else begin
              tx_cnt <= tx_cnt + CW'(1);
            end
          end
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

  // ---------------- receiver ----------------
  logic [1:0] rx_sync;
  logic       rx_s;
  logic       rx_prev;

  assign rx_s = rx_sync[1];

  // Line synchronizer; resets to the idle-high level so release never looks like a start edge
  always_ff @(posedge clk_sis or negedge rst) begin
    if (!rst) begin
      rx_sync <= 2'b11;
      rx_prev <= 1'b1;
    end else begin
      rx_sync <= {rx_sync[0], rx1};
      rx_prev <= rx_s;
    end
  end

  rx_state_t         rx_state;
  logic [CW-1:0]     rx_cnt;
  logic [2:0]        rx_bit;
  logic [DATA_W-1:0] rx_shreg;

  // RX FSM: samples at bit midpoints measured from the detected start edge
  always_ff @(posedge clk_sis or negedge rst) begin
    if (!rst) begin
      rx_state    <= RX_IDLE;
      rx_cnt      <= '0;
      rx_bit      <= 3'd0;
      rx_shreg    <= '0;
      data_out_1  <= '0;
      rx_valid_1  <= 1'b0;
      frame_err_1 <= 1'b0;
    end else begin
      rx_valid_1  <= 1'b0;
      frame_err_1 <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          if (rx_prev && !rx_s) begin
            rx_cnt   <= '0;
            rx_state <= RX_START;
          end
        end
        RX_START: begin
          if (tick) begin
            if (rx_cnt == HALF) begin
              rx_cnt   <= '0;
              rx_bit   <= 3'd0;
              rx_state <= rx_s ? RX_IDLE : RX_DATA;
            end else begin
              rx_cnt <= rx_cnt + CW'(1);
            end
          end
        end
        RX_DATA: begin
          if (tick) begin
            if (rx_cnt == LAST) begin
              rx_cnt   <= '0;
              rx_shreg <= {rx_s, rx_shreg[DATA_W-1:1]};
              rx_bit   <= rx_bit + 3'd1;
              if (rx_bit == 3'd7) rx_state <= RX_STOP;
            end else begin
              rx_cnt <= rx_cnt + CW'(1);
            end
          end
        end
        RX_STOP: begin
          if (tick) begin
            if (rx_cnt == LAST) begin
              rx_cnt <= '0;
              if (rx_s) begin
                data_out_1 <= rx_shreg;
                rx_valid_1 <= 1'b1;
                rx_state   <= RX_IDLE;
              end else begin
                frame_err_1 <= 1'b1;
                rx_state    <= RX_WAIT;
              end
            end else begin
              rx_cnt <= rx_cnt + CW'(1);
            end
          end
        end
        RX_WAIT: begin
          if (rx_s) rx_state <= RX_IDLE;
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart1_dut.sv
// tb/tb_uart1_dut.sv - scoreboard bench for uart1_dut / uart2_dut
module tb_uart1_dut;

  localparam int OVS = 16;
  localparam int P   = 4;
  localparam int BIT = OVS * P;

  logic       clk_sis = 1'b0;
  logic       clk_uart = 1'b0;
  logic       rst = 1'b0;
  logic       start_bit = 1'b0, start_bit_2 = 1'b0;
  logic [7:0] data_in_1 = 8'h00, data_in_2 = 8'h00;
  logic       stop_bit = 1'b0, stop_bit_2 = 1'b0;
  logic       tx1, tx2, rx1, rx2;
  logic [7:0] data_out_1, data_out_2;
  logic       rx_valid_1, frame_err_1, tx_busy_1;
  logic       rx_valid_2, frame_err_2, tx_busy_2;
  logic       loop = 1'b0, dup = 1'b0, rx_drv = 1'b1;

  int tests = 0;
  int fails = 0;

  typedef struct {
    bit         err;
    logic [7:0] data;
  } exp_t;

  exp_t       q1[$];
  logic [7:0] q2[$];

  assign rx1 = dup ? tx2 : (loop ? tx1 : rx_drv);
  assign rx2 = dup ? tx1 : 1'b1;

  uart1_dut #(.OVS(OVS)) dut (
    .clk_sis     (clk_sis),
    .rst         (rst),
    .clk_uart    (clk_uart),
    .start_bit   (start_bit),
    .data_in_1   (data_in_1),
    .stop_bit    (stop_bit),
    .tx1         (tx1),
    .rx1         (rx1),
    .data_out_1  (data_out_1),
    .rx_valid_1  (rx_valid_1),
    .frame_err_1 (frame_err_1),
    .tx_busy_1   (tx_busy_1)
  );

  uart2_dut #(.OVS(OVS)) dut2 (
    .clk_sis     (clk_sis),
    .rst         (rst),
    .clk_uart    (clk_uart),
    .start_bit_2 (start_bit_2),
    .data_in_2   (data_in_2),
    .stop_bit_2  (stop_bit_2),
    .tx2         (tx2),
    .rx2         (rx2),
    .data_out_2  (data_out_2),
    .rx_valid_2  (rx_valid_2),
    .frame_err_2 (frame_err_2),
    .tx_busy_2   (tx_busy_2)
  );

  always #5 clk_sis = ~clk_sis;

  initial begin
    #2;
    forever begin
      clk_uart = 1'b1;
      #20;
      clk_uart = 1'b0;
      #20;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor for channel 1: every rx_valid_1/frame_err_1 pulse must match the queue head
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_sis);
      if (rx_valid_1 || frame_err_1) begin
        tests++;
        if (q1.size() == 0) begin
          fails++;
          $display("FAIL sb1_spurious: got valid=%0b err=%0b data=%0h expected no event",
                   rx_valid_1, frame_err_1, data_out_1);
        end else begin
          e = q1.pop_front();
          if (frame_err_1 !== e.err || rx_valid_1 !== !e.err || data_out_1 !== e.data) begin
            fails++;
            $display("FAIL sb1_event: got err=%0b valid=%0b data=%0h expected err=%0b data=%0h",
                     frame_err_1, rx_valid_1, data_out_1, e.err, e.data);
          end
        end
      end
    end
  end

  // Monitor for channel 2
  initial begin
    logic [7:0] d;
    forever begin
      @(negedge clk_sis);
      if (rx_valid_2 || frame_err_2) begin
        tests++;
        if (q2.size() == 0) begin
          fails++;
          $display("FAIL sb2_spurious: got valid=%0b err=%0b data=%0h expected no event",
                   rx_valid_2, frame_err_2, data_out_2);
        end else begin
          d = q2.pop_front();
          if (!rx_valid_2 || frame_err_2 || data_out_2 !== d) begin
            fails++;
            $display("FAIL sb2_event: got valid=%0b err=%0b data=%0h expected valid data=%0h",
                     rx_valid_2, frame_err_2, data_out_2, d);
          end
        end
      end
    end
  end

  // which: 0 = tx1, 1 = tx_busy_1, 2 = tx_busy_2
  task automatic wait_sig(input string nm, input int which, input logic val, output int cyc);
    logic s;
    cyc = 0;
    forever begin
      @(negedge clk_sis);
      cyc++;
      s = (which == 0) ? tx1 : ((which == 1) ? tx_busy_1 : tx_busy_2);
      if (s === val || cyc >= 5000) break;
    end
    if (cyc >= 5000) begin
      tests++;
      fails++;
      $display("FAIL %s: got timeout after %0d cycles expected level %0b", nm, cyc, val);
    end
  endtask

  task automatic start_tx(input logic [7:0] d, input logic sb);
    @(negedge clk_sis);
    data_in_1 = d;
    stop_bit  = sb;
    start_bit = 1'b1;
    @(negedge clk_sis);
    start_bit = 1'b0;
  endtask

  task automatic send_raw(input logic [7:0] d, input logic sv);
    @(negedge clk_sis);
    rx_drv = 1'b0;
    repeat (BIT) @(negedge clk_sis);
    for (int i = 0; i < 8; i++) begin
      rx_drv = d[i];
      repeat (BIT) @(negedge clk_sis);
    end
    rx_drv = sv;
    repeat (BIT) @(negedge clk_sis);
    rx_drv = 1'b1;
    repeat (BIT) @(negedge clk_sis);
  endtask

  initial begin
    int c;
    exp_t e;

    // reset state
    rst = 1'b0;
    repeat (4) @(negedge clk_sis);
    chk("rst_tx1", tx1, 1);
    chk("rst_busy", tx_busy_1, 0);
    chk("rst_data_out", data_out_1, 8'h00);
    chk("rst_valid", rx_valid_1, 0);
    chk("rst_ferr", frame_err_1, 0);
    rst = 1'b1;
    repeat (20) @(negedge clk_sis);

    // loopback A5, inputs changed mid-frame must be ignored
    loop = 1'b1;
    e.err = 1'b0; e.data = 8'hA5; q1.push_back(e);
    start_tx(8'hA5, 1'b0);
    chk("lb_busy_set", tx_busy_1, 1);
    data_in_1 = 8'hFF;
    stop_bit  = 1'b1;
    wait_sig("lb_tx_fall", 0, 1'b0, c);
    wait_sig("lb_busy_fall", 1, 1'b0, c);
    chk("lb_frame_cycles", c, 10 * BIT);
    repeat (100) @(negedge clk_sis);
    chk("lb_sb_drained", q1.size(), 0);
    chk("lb_data_out", data_out_1, 8'hA5);

    // two stop bits, data 00
    e.err = 1'b0; e.data = 8'h00; q1.push_back(e);
    start_tx(8'h00, 1'b1);
    stop_bit = 1'b0;
    wait_sig("s2_tx_fall", 0, 1'b0, c);
    wait_sig("s2_tx_rise", 0, 1'b1, c);
    chk("s2_low_cycles", c, 9 * BIT);
    wait_sig("s2_busy_fall", 1, 1'b0, c);
    chk("s2_high_cycles", c, 2 * BIT);
    chk("s2_tx_idle", tx1, 1);
    repeat (100) @(negedge clk_sis);
    chk("s2_sb_drained", q1.size(), 0);
    loop = 1'b0;

    // full duplex cross-coupled
    dup = 1'b1;
    e.err = 1'b0; e.data = 8'hC3; q1.push_back(e);
    q2.push_back(8'h3C);
    @(negedge clk_sis);
    data_in_1 = 8'h3C; data_in_2 = 8'hC3;
    start_bit = 1'b1;  start_bit_2 = 1'b1;
    @(negedge clk_sis);
    start_bit = 1'b0;  start_bit_2 = 1'b0;
    wait_sig("fd_busy1", 1, 1'b0, c);
    wait_sig("fd_busy2", 2, 1'b0, c);
    repeat (100) @(negedge clk_sis);
    chk("fd_sb1_drained", q1.size(), 0);
    chk("fd_sb2_drained", q2.size(), 0);
    chk("fd_data_out_1", data_out_1, 8'hC3);
    chk("fd_data_out_2", data_out_2, 8'h3C);
    dup = 1'b0;
    repeat (20) @(negedge clk_sis);

    // false start: low for OVS/4 ticks, then a real frame must still be received
    rx_drv = 1'b0;
    repeat ((OVS / 4) * P) @(negedge clk_sis);
    rx_drv = 1'b1;
    repeat (3 * BIT) @(negedge clk_sis);
    chk("fs_data_kept", data_out_1, 8'hC3);
    e.err = 1'b0; e.data = 8'h2D; q1.push_back(e);
    send_raw(8'h2D, 1'b1);
    chk("fs_sb_drained", q1.size(), 0);
    chk("fs_next_frame", data_out_1, 8'h2D);

    // framing error, then recovery
    e.err = 1'b1; e.data = 8'h2D; q1.push_back(e);
    send_raw(8'h55, 1'b0);
    chk("fe_sb_drained", q1.size(), 0);
    chk("fe_data_kept", data_out_1, 8'h2D);
    e.err = 1'b0; e.data = 8'h1E; q1.push_back(e);
    send_raw(8'h1E, 1'b1);
    chk("fe_recover_drained", q1.size(), 0);
    chk("fe_recover_data", data_out_1, 8'h1E);

    // reset mid-frame during data bits
    loop = 1'b1;
    start_tx(8'hA5, 1'b0);
    wait_sig("rm_tx_fall", 0, 1'b0, c);
    repeat (3 * BIT) @(negedge clk_sis);
    chk("rm_busy_mid", tx_busy_1, 1);
    #1 rst = 1'b0;
    #1;
    chk("rm_tx1", tx1, 1);
    chk("rm_busy", tx_busy_1, 0);
    @(negedge clk_sis);
    rst = 1'b1;
    repeat (12 * BIT) @(negedge clk_sis);
    chk("rm_busy_after", tx_busy_1, 0);
    chk("rm_data_out", data_out_1, 8'h00);
    chk("rm_sb_empty", q1.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
